program_counter: RTL

- Upstream neighbour of the instruction register; owns the program-memory fetch address.
- Holds the PC and the 2-level hardware return stack.
- Once per instruction cycle, at execute Q4, decodes GOTO/CALL/RETLW from the executing instruction, plus PCL writes, and loads the next fetch address.
- Drives the branch-flush strobe that the instruction register samples at EX_Q1 to turn the already-fetched instruction into a NOP.

---
 rtl/program_counter_pkg.sv | 46 ++++
 rtl/program_counter_if.sv | 28 ++
 rtl/program_counter_return_stack.sv | 51 +++++
 rtl/program_counter.sv | 80 ++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared constants for the fetch-address block: execute phases, opcode masks and branch decode.
// Imported by the program counter, its return stack and the bus interface.
package program_counter_pkg;

  localparam int INST_WIDTH    = 12;
  localparam int EX_STATE_BITS = 2;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1 = 2'd0,
    EX_Q2 = 2'd1,
    EX_Q3 = 2'd2,
    EX_Q4 = 2'd3
  } ex_state_t;

  localparam logic [INST_WIDTH-1:0] I_GOTO_MASK = 12'hE00;
  localparam logic [INST_WIDTH-1:0] I_GOTO      = 12'hA00;
  localparam logic [INST_WIDTH-1:0] I_CALL_MASK = 12'hF00;
  localparam logic [INST_WIDTH-1:0] I_CALL      = 12'h900;
  localparam logic [INST_WIDTH-1:0] I_RETLW     = 12'h800;
  localparam logic [INST_WIDTH-1:0] I_NOP_12    = 12'h000;
  localparam logic [7:0]            PCL_ADDR    = 8'h02;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_GOTO,
    BR_CALL,
    BR_RETLW,
    BR_PCL
  } branch_t;

  // Instruction-decoded branches outrank a concurrent PCL write.
  function automatic branch_t decode_branch(logic [INST_WIDTH-1:0] ir, logic pcl_we);
    branch_t br;
    br = BR_NONE;
    if ((ir & I_GOTO_MASK) == I_GOTO)
      br = BR_GOTO;
    else if ((ir & I_CALL_MASK) == I_CALL)
      br = BR_CALL;
    else if ((ir & I_CALL_MASK) == I_RETLW)
      br = BR_RETLW;
    else if (pcl_we)
      br = BR_PCL;
    return br;
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Bus between the core (master) and the program counter (slave).
// Carries the execute phase, instruction, page bits, PCL write port and PC/stack status.
interface program_counter_if #(parameter int PC_WIDTH = 11);
  import program_counter_pkg::*;

  logic [EX_STATE_BITS-1:0] executeState;
  logic [INST_WIDTH-1:0]    ir;
  logic [1:0]               pa;
  logic                     pcl_we;
  logic [7:0]               pcl_data;
  logic [PC_WIDTH-1:0]      pc;
  logic [7:0]               pcl;
  logic                     goto;
  logic [1:0]               stk_depth;
  logic                     stk_ovf;
  logic                     stk_unf;

  modport master (
    output executeState, ir, pa, pcl_we, pcl_data,
    input  pc, pcl, goto, stk_depth, stk_ovf, stk_unf
  );

  modport slave (
    input  executeState, ir, pa, pcl_we, pcl_data,
    output pc, pcl, goto, stk_depth, stk_ovf, stk_unf
  );

endinterface

// File: rtl/program_counter_return_stack.sv
// Hardware return stack: shift-register LIFO whose bottom level duplicates on pop,
// with a saturating depth counter and sticky overflow/underflow flags.
module return_stack #(
  parameter  int WIDTH   = 11,
  parameter  int DEPTH   = 2,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   top,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf,
  output logic               unf
);

  logic [WIDTH-1:0]   levels [DEPTH];
  logic [DEPTH_W-1:0] count;

  // A push at full depth drops the deepest entry; a pop leaves the deepest entry in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        levels[i] <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      levels[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        levels[i] <= levels[i-1];
      if (count == DEPTH_W'(DEPTH))
        ovf <= 1'b1;
      else
        count <= count + DEPTH_W'(1);
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++)
        levels[i] <= levels[i+1];
      if (count == '0)
        unf <= 1'b1;
      else
        count <= count - DEPTH_W'(1);
    end
  end

  assign top   = levels[0];
  assign depth = count;

endmodule

// File: rtl/program_counter.sv
// Fetch-address owner: selects the next PC once per instruction at EX_Q4 and
// registers the branch-flush strobe consumed by the instruction register.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int PC_WIDTH    = 11,
  parameter int STACK_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  program_counter_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;
  logic                goto_q;
  logic                goto_next;
  logic                ex_q4;
  branch_t             br;
  logic [10:0]         goto_target;
  logic [10:0]         call_target;
  logic [10:0]         pcl_target;
  logic [1:0]          depth;
  logic                ovf;
  logic                unf;

  assign ex_q4 = (bus.executeState == EX_Q4);
  assign br    = decode_branch(bus.ir, bus.pcl_we);

  // Targets are formed at full 11-bit width, then the page bits are truncated to PC_WIDTH.
  assign goto_target = {bus.pa, bus.ir[8:0]};
  assign call_target = {bus.pa, 1'b0, bus.ir[7:0]};
  assign pcl_target  = {bus.pa, 1'b0, bus.pcl_data};

  always_comb begin
    pc_next   = pc_q + PC_WIDTH'(1);
    goto_next = 1'b1;
    case (br)
      BR_GOTO:  pc_next = goto_target[PC_WIDTH-1:0];
      BR_CALL:  pc_next = call_target[PC_WIDTH-1:0];
      BR_RETLW: pc_next = stack_top;
      BR_PCL:   pc_next = pcl_target[PC_WIDTH-1:0];
      default:  goto_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '1;
      goto_q <= 1'b0;
    end else if (ex_q4) begin
      pc_q   <= pc_next;
      goto_q <= goto_next;
    end
  end

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (ex_q4 && (br == BR_CALL)),
    .pop   (ex_q4 && (br == BR_RETLW)),
    .din   (pc_q),
    .top   (stack_top),
    .depth (depth),
    .ovf   (ovf),
    .unf   (unf)
  );

  assign bus.pc        = pc_q;
  assign bus.pcl       = pc_q[7:0];
  assign bus.goto      = goto_q;
  assign bus.stk_depth = depth;
  assign bus.stk_ovf   = ovf;
  assign bus.stk_unf   = unf;

endmodule
